// File: rtl/fetch_decode_ctrl_if.sv
// fetch_decode_ctrl_if
//  Bundles the instruction-ROM bus and the RF_plus_ALU control/flag bus that
//  connect the fetch/decode controller to the single-cycle datapath.
//  Signals:
//   instr_addr   PC_WIDTH  ROM address (controller -> ROM)
//   instr_data   16        ROM data, combinational from instr_addr
//   Z,N,C,V      1 each    ALU flags of the instruction being decoded
//   Read_Addr_A/Read_Addr_B/Write_Addr  3  RF addresses
//   Write_En, Src_ALU_B, ADC, SUB, SBB  1  RF/ALU controls
//   imm5         5         immediate operand
//   Pre_C        1         stored carry fed back to the ALU
//  Modports: master = controller side, slave = ROM/datapath side.
interface fetch_decode_ctrl_if #(
  parameter int PC_WIDTH = 8
);
  logic [PC_WIDTH-1:0] instr_addr;
  logic [15:0]         instr_data;
  logic                Z;
  logic                N;
  logic                C;
  logic                V;
  logic [2:0]          Read_Addr_A;
  logic [2:0]          Read_Addr_B;
  logic [2:0]          Write_Addr;
  logic                Write_En;
  logic                Src_ALU_B;
  logic [4:0]          imm5;
  logic                ADC;
  logic                SUB;
  logic                SBB;
  logic                Pre_C;

  modport master (
    output instr_addr,
    input  instr_data,
    input  Z, N, C, V,
    output Read_Addr_A, Read_Addr_B, Write_Addr,
    output Write_En, Src_ALU_B, imm5,
    output ADC, SUB, SBB, Pre_C
  );

  modport slave (
    input  instr_addr,
    output instr_data,
    output Z, N, C, V,
    input  Read_Addr_A, Read_Addr_B, Write_Addr,
    input  Write_En, Src_ALU_B, imm5,
    input  ADC, SUB, SBB, Pre_C
  );
endinterface

// File: rtl/fetch_decode_ctrl.sv
// fetch_decode_ctrl
//  Upstream control stage of the single-cycle RISC datapath: holds the PC,
//  fetches one 16-bit instruction per clock from a combinational ROM, decodes
//  it into RF/ALU controls and keeps the Z/N/C/V flag register used by the
//  conditional branches.
//  Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   1-cycle pulse, IDLE -> RUN
//   bus        master modport of fetch_decode_ctrl_if (ROM bus + RF/ALU controls)
//   halted     out  1 in HALT (and TRAP)
//   illegal_op out  1 while an undefined opcode is decoded in RUN
//  Build option:
//   OVERFLOW_TRAP_EN  when defined, an ALU op with V=1 commits its result and
//                     flags, then parks the FSM in TRAP with the PC frozen at
//                     the faulting instruction.
module fetch_decode_ctrl #(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = {PC_WIDTH{1'b0}}
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  fetch_decode_ctrl_if.master bus,
  output logic                halted,
  output logic                illegal_op
);

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_ADD  = 5'b00001;
  localparam logic [4:0] OP_ADC  = 5'b00010;
  localparam logic [4:0] OP_SUB  = 5'b00011;
  localparam logic [4:0] OP_SBB  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BZ   = 5'b01000;
  localparam logic [4:0] OP_BNZ  = 5'b01001;
  localparam logic [4:0] OP_BC   = 5'b01010;
  localparam logic [4:0] OP_BN   = 5'b01011;
  localparam logic [4:0] OP_JMP  = 5'b01100;
  localparam logic [4:0] OP_HALT = 5'b11111;

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
`ifdef OVERFLOW_TRAP_EN
    ST_HALT = 2'd2,
    ST_TRAP = 2'd3
`else
    ST_HALT = 2'd2
`endif
  } state_e;

  state_e              state_q;
  state_e              state_d;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;
  // flags_q = {Z, N, C, V}
  logic [3:0]          flags_q;
  logic [3:0]          flags_d;

  logic [4:0]          op_s;
  logic                run_s;
  logic                alu_s;
  logic                branch_s;
  logic                take_s;
  logic                jmp_s;
  logic                halt_s;
  logic                illegal_s;
  logic                adc_s;
  logic                sub_s;
  logic                sbb_s;
  logic                src_b_s;
  logic [2:0]          ra_s;
  logic [2:0]          rb_s;
  logic [2:0]          rd_s;
  logic [4:0]          imm_s;
  logic [PC_WIDTH-1:0] pc_plus1_s;
  logic [PC_WIDTH-1:0] br_tgt_s;
  logic [PC_WIDTH-1:0] jmp_tgt_s;

  assign op_s  = bus.instr_data[15:11];
  // Decoding is only live in RUN; rst_n is folded in so a reset shows up on the
  // controls without waiting for the state register.
  assign run_s = rst_n && (state_q == ST_RUN);

  assign pc_plus1_s = pc_q + PC_ONE;
  // Signed cast sign-extends off8 (or truncates it for narrow PCs).
  assign br_tgt_s   = pc_plus1_s + PC_WIDTH'($signed(bus.instr_data[7:0]));
  assign jmp_tgt_s  = PC_WIDTH'(bus.instr_data[10:0]);

  // Instruction decode, gated by RUN.
  always_comb begin
    alu_s     = 1'b0;
    branch_s  = 1'b0;
    take_s    = 1'b0;
    jmp_s     = 1'b0;
    halt_s    = 1'b0;
    illegal_s = 1'b0;
    adc_s     = 1'b0;
    sub_s     = 1'b0;
    sbb_s     = 1'b0;
    src_b_s   = 1'b0;
    ra_s      = 3'd0;
    rb_s      = 3'd0;
    rd_s      = 3'd0;
    imm_s     = 5'd0;
    if (run_s) begin
      rd_s  = bus.instr_data[10:8];
      ra_s  = bus.instr_data[7:5];
      rb_s  = bus.instr_data[4:2];
      imm_s = bus.instr_data[4:0];
      case (op_s)
        OP_NOP:  alu_s = 1'b0;
        OP_ADD:  alu_s = 1'b1;
        OP_ADC:  begin alu_s = 1'b1; adc_s   = 1'b1; end
        OP_SUB:  begin alu_s = 1'b1; sub_s   = 1'b1; end
        OP_SBB:  begin alu_s = 1'b1; sbb_s   = 1'b1; end
        OP_ADDI: begin alu_s = 1'b1; src_b_s = 1'b1; end
        // Branches test the registered flags, never the live ALU flags.
        OP_BZ:   begin branch_s = 1'b1; take_s = flags_q[3];  end
        OP_BNZ:  begin branch_s = 1'b1; take_s = ~flags_q[3]; end
        OP_BC:   begin branch_s = 1'b1; take_s = flags_q[1];  end
        OP_BN:   begin branch_s = 1'b1; take_s = flags_q[2];  end
        OP_JMP:  jmp_s  = 1'b1;
        OP_HALT: halt_s = 1'b1;
        default: illegal_s = 1'b1;
      endcase
    end else begin
      alu_s     = 1'b0;
      illegal_s = 1'b0;
    end
  end

  // Next-state, next-PC and flag-update logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flags_d = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (alu_s) begin
          flags_d = {bus.Z, bus.N, bus.C, bus.V};
`ifdef OVERFLOW_TRAP_EN
          if (bus.V) begin
            // Result still commits; PC stays on the faulting instruction.
            state_d = ST_TRAP;
            pc_d    = pc_q;
          end else begin
            pc_d = pc_plus1_s;
          end
`else
          pc_d = pc_plus1_s;
`endif
        end else if (halt_s) begin
          state_d = ST_HALT;
          pc_d    = pc_q;
        end else if (jmp_s) begin
          pc_d = jmp_tgt_s;
        end else if (branch_s && take_s) begin
          pc_d = br_tgt_s;
        end else begin
          pc_d = pc_plus1_s;
        end
      end
      ST_HALT: state_d = ST_HALT;
`ifdef OVERFLOW_TRAP_EN
      ST_TRAP: state_d = ST_TRAP;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State, PC and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
    end
  end

  assign bus.instr_addr  = pc_q;
  assign bus.Read_Addr_A = ra_s;
  assign bus.Read_Addr_B = rb_s;
  assign bus.Write_Addr  = rd_s;
  assign bus.Write_En    = alu_s;
  assign bus.Src_ALU_B   = src_b_s;
  assign bus.imm5        = imm_s;
  assign bus.ADC         = adc_s;
  assign bus.SUB         = sub_s;
  assign bus.SBB         = sbb_s;
  assign bus.Pre_C       = flags_q[1];
  assign illegal_op      = illegal_s;
`ifdef OVERFLOW_TRAP_EN
  assign halted = (state_q == ST_HALT) || (state_q == ST_TRAP);
`else
  assign halted = (state_q == ST_HALT);
`endif

endmodule
